// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES ciphertext UART transmit scheduler.
package aes_uart_pkg;

  localparam int unsigned BLK_BYTES = 16;
  localparam logic [7:0] FRAME_MARKER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT
  } state_t;

endpackage

// File: rtl/aes_uart_tx_sched_uart_tx.sv
// 8N1 UART transmitter: one start pulse while ready sends one frame, LSB first.
module uart_tx #(
  parameter logic [23:0] BAUD_RATE  = 24'd4000000,
  parameter logic [27:0] CLOCK_FREQ = 28'd50000000
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       d_out
);

  localparam int unsigned BIT_CYCLES = int'(CLOCK_FREQ / BAUD_RATE);
  localparam logic [15:0] BAUD_LAST  = 16'(BIT_CYCLES - 1);

  logic        sending;
  logic [9:0]  frame;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      sending  <= 1'b0;
      frame    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else if (!sending) begin
      if (start) begin
        sending  <= 1'b1;
        frame    <= {1'b1, data, 1'b0};
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      frame    <= {1'b1, frame[9:1]};
      if (bit_cnt == 4'd9) sending <= 1'b0;
      else                 bit_cnt <= bit_cnt + 4'd1;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Line idles high and is forced high the instant reset drops sending.
  assign d_out = sending ? frame[0] : 1'b1;
  assign ready = !sending;

endmodule

// File: rtl/aes_uart_tx_sched.sv
// Serialises 128-bit AES blocks over UART, MSB byte first, one uart_tx frame per byte.
// Optional build macro TX_FRAME_MARKER_EN prepends an 8'hA5 header byte to every block.
module aes_uart_tx_sched
  import aes_uart_pkg::*;
#(
  parameter logic [23:0] BAUD_RATE  = 24'd4000000,
  parameter logic [27:0] CLOCK_FREQ = 28'd50000000
) (
  input  logic         uart_clock,
  input  logic         uart_reset,
  input  logic         blk_valid,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         uart_d_out,
  output logic         busy,
  output logic [4:0]   byte_idx,
  output logic         blk_done
);

  state_t       state, state_nx;
  logic [127:0] shift_reg;
  logic         tx_start, tx_ready, marker_slot, last_byte;
  logic [7:0]   tx_byte;

`ifdef TX_FRAME_MARKER_EN
  localparam logic [4:0] LAST_IDX = 5'(BLK_BYTES);
  assign marker_slot = (byte_idx == 5'd0);
`else
  localparam logic [4:0] LAST_IDX = 5'(BLK_BYTES - 1);
  assign marker_slot = 1'b0;
`endif

  assign last_byte = (byte_idx == LAST_IDX);
  assign tx_byte   = marker_slot ? FRAME_MARKER : shift_reg[127:120];
  assign blk_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) state <= IDLE;
    else             state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    tx_start = 1'b0;
    blk_done = 1'b0;
    case (state)
      IDLE:      if (blk_valid) state_nx = PULSE;
      PULSE: begin
        tx_start = 1'b1;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: if (!tx_ready) state_nx = WAIT_IDLE;
      WAIT_IDLE: if (tx_ready)  state_nx = NEXT;
      NEXT: begin
        blk_done = last_byte;
        state_nx = last_byte ? IDLE : PULSE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // NOTE: the payload register is reset as well, so no ciphertext survives a reset.
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      shift_reg <= '0;
      byte_idx  <= '0;
    end else if (state == IDLE && blk_valid) begin
      shift_reg <= blk_data;
      byte_idx  <= '0;
    end else if (state == NEXT) begin
      if (!marker_slot) shift_reg <= {shift_reg[119:0], 8'h00};
      byte_idx <= last_byte ? 5'd0 : byte_idx + 5'd1;
    end
  end

  uart_tx #(
    .BAUD_RATE (BAUD_RATE),
    .CLOCK_FREQ(CLOCK_FREQ)
  ) u_uart_tx (
    .uart_clock(uart_clock),
    .uart_reset(uart_reset),
    .start     (tx_start),
    .data      (tx_byte),
    .ready     (tx_ready),
    .d_out     (uart_d_out)
  );

endmodule
